conf_link_ctrl: RTL and testbench

Parametrised RS232 configuration-link controller, the successor to the fixed main/write/read control FSM trio. It decodes framed commands from the UART receiver and performs addressed, variable-length burst writes into a configuration register file, or burst reads from it back through the UART transmitter. Compared with the previous controller it adds:
- start address and length fields, with wrap-around addressing;
- a receive inter-byte timeout;
- error reporting.

It sits between the RS232 RX/TX cores and the configuration register bank.

---
 rtl/conf_link_ctrl_pkg.sv | 30 +++
 rtl/conf_link_ctrl_frame_timer.sv | 39 +++
 rtl/conf_link_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_conf_link_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_link_ctrl_pkg.sv
// Shared definitions for the configuration-link controller: FSM state
// encodings (also shown on the debug LEDs), error codes and the default
// command bytes.
package conf_link_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GET_ADDR = 4'd1,
    ST_GET_LEN  = 4'd2,
    ST_WR_DATA  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_RD_GAP   = 4'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CMD     = 2'b01,
    ERR_LEN     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  localparam logic [7:0] CMD_WR_DEFAULT = 8'h57;
  localparam logic [7:0] CMD_RD_DEFAULT = 8'h52;

  // States in which the inter-byte receive timeout is armed.
  function automatic logic is_timed(state_e s);
    return (s == ST_GET_ADDR) || (s == ST_GET_LEN) || (s == ST_WR_DATA);
  endfunction

endpackage

// File: rtl/conf_link_ctrl_frame_timer.sv
// Inter-byte frame timer: counts enabled cycles since the last clear and
// flags terminal count once TO_CYCLES idle cycles have elapsed. The count
// saturates at terminal count so the flag stays up until cleared.
module conf_link_ctrl_frame_timer #(
  parameter int TO_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TO_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled, saturating.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/conf_link_ctrl.sv
// RS232 configuration-link controller. Decodes cmd/addr/len frames from the
// UART receiver and performs wrapping burst writes into the register bank or
// burst reads from it back out through the UART transmitter.
module conf_link_ctrl
  import conf_link_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = 3,
  parameter logic [7:0] CMD_WR    = CMD_WR_DEFAULT,
  parameter logic [7:0] CMD_RD    = CMD_RD_DEFAULT,
  parameter int         TO_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxdw,
  input  logic              rxrdy,
  input  logic              txbusy,
  output logic              txena,
  output logic [7:0]        txdw,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic [1:0]        err,
  output logic [3:0]        sleds
);

  state_e              state_q, state_d;
  logic                dir_rd_q, dir_rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          rem_q, rem_d;
  err_e                err_q, err_d;
  logic                txena_q, txena_d;
  logic [7:0]          txdw_q, txdw_d;
  logic                reg_we_q, reg_we_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          reg_wdata_q, reg_wdata_d;

  logic is_cmd;
  logic timer_tc;

  assign is_cmd = (rxdw == CMD_WR) || (rxdw == CMD_RD);

  // The timer runs only in the receive states; it is held cleared elsewhere,
  // so entering a timed state always starts from zero, and every received
  // byte restarts it.
  conf_link_ctrl_frame_timer #(
    .TO_CYCLES (TO_CYCLES)
  ) u_frame_timer (
    .clk (clk),
    .rst (rst),
    .clr (rxrdy || !is_timed(state_q)),
    .en  (is_timed(state_q)),
    .tc  (timer_tc)
  );

  // State and datapath registers; reset returns everything to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_rd_q    <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      err_q       <= ERR_NONE;
      txena_q     <= 1'b0;
      txdw_q      <= '0;
      reg_we_q    <= 1'b0;
      wr_addr_q   <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_rd_q    <= dir_rd_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      txena_q     <= txena_d;
      txdw_q      <= txdw_d;
      reg_we_q    <= reg_we_d;
      wr_addr_q   <= wr_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // Next-state logic. A byte arriving on the terminal-count cycle wins over
  // the timeout because rxrdy is tested first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rxrdy && is_cmd) state_d = ST_GET_ADDR;
      end
      ST_GET_ADDR: begin
        if (rxrdy)         state_d = ST_GET_LEN;
        else if (timer_tc) state_d = ST_IDLE;
      end
      ST_GET_LEN: begin
        if (rxrdy) begin
          if (rxdw == 8'd0)  state_d = ST_IDLE;
          else if (dir_rd_q) state_d = ST_RD_WAIT;
          else               state_d = ST_WR_DATA;
        end else if (timer_tc) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (rxrdy) begin
          if (rem_q == 8'd1) state_d = ST_IDLE;
        end else if (timer_tc) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (!txbusy) state_d = ST_RD_GAP;
      end
      ST_RD_GAP: begin
        state_d = (rem_q == 8'd1) ? ST_IDLE : ST_RD_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / registered-output next values. Strobes default low so each
  // pulse lasts exactly one cycle; rxrdy is ignored in the read states.
  always_comb begin
    dir_rd_d    = dir_rd_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    err_d       = err_q;
    txena_d     = 1'b0;
    txdw_d      = txdw_q;
    reg_we_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    reg_wdata_d = reg_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rxrdy) begin
          if (is_cmd) begin
            dir_rd_d = (rxdw == CMD_RD);
            err_d    = ERR_NONE;
          end else begin
            err_d    = ERR_CMD;
          end
        end
      end
      ST_GET_ADDR: begin
        if (rxrdy)         addr_d = rxdw[ADDR_W-1:0];
        else if (timer_tc) err_d  = ERR_TIMEOUT;
      end
      ST_GET_LEN: begin
        if (rxrdy) begin
          if (rxdw == 8'd0) err_d = ERR_LEN;
          else              rem_d = rxdw;
        end else if (timer_tc) begin
          err_d = ERR_TIMEOUT;
        end
      end
      ST_WR_DATA: begin
        if (rxrdy) begin
          reg_we_d    = 1'b1;
          wr_addr_d   = addr_q;
          reg_wdata_d = rxdw;
          addr_d      = addr_q + ADDR_W'(1);
          rem_d       = rem_q - 8'd1;
        end else if (timer_tc) begin
          err_d = ERR_TIMEOUT;
        end
      end
      ST_RD_WAIT: begin
        if (!txbusy) begin
          txdw_d  = reg_rdata;
          txena_d = 1'b1;
        end
      end
      ST_RD_GAP: begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - 8'd1;
      end
      default: ;
    endcase
  end

  // During reads the bank is addressed straight from the address counter so
  // reg_rdata is valid when txdw is captured; writes present the address
  // registered alongside the write strobe.
  assign reg_addr  = ((state_q == ST_RD_WAIT) || (state_q == ST_RD_GAP)) ? addr_q : wr_addr_q;
  assign txena     = txena_q;
  assign txdw      = txdw_q;
  assign reg_we    = reg_we_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign sleds     = state_q;

endmodule

// File: tb/tb_conf_link_ctrl.sv
// Directed bench for conf_link_ctrl: write/read bursts, wrap-around, zero
// length, timeout (and its boundary), unknown command, reset mid-frame.
module tb_conf_link_ctrl;

  localparam int ADDR_W = 3;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rxdw;
  logic              rxrdy;
  logic              txbusy;
  logic              txena;
  logic [7:0]        txdw;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic [1:0]        err;
  logic [3:0]        sleds;

  conf_link_ctrl #(
    .ADDR_W    (ADDR_W),
    .CMD_WR    (8'h57),
    .CMD_RD    (8'h52),
    .TO_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxdw      (rxdw),
    .rxrdy     (rxrdy),
    .txbusy    (txbusy),
    .txena     (txena),
    .txdw      (txdw),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .err       (err),
    .sleds     (sleds)
  );

  always #5 clk = ~clk;

  // Register bank model with combinational read.
  logic [7:0] mem [8];
  assign reg_rdata = mem[reg_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observation logs filled by the monitor below.
  logic [7:0] wa_q [$];
  logic [7:0] wd_q [$];
  logic [7:0] tx_q [$];
  int tx_viol  = 0;
  int min_gap  = 1000;
  int cyc      = 0;
  int last_tx  = -1000;
  int busy_cnt = 0;
  logic prev_txena = 1'b0;

  // Monitor and transmitter model, evaluated mid-cycle. txbusy rises the
  // cycle after each txena pulse and stays high for 10 cycles.
  always @(negedge clk) begin
    cyc++;
    if (reg_we) begin
      wa_q.push_back(8'(reg_addr));
      wd_q.push_back(reg_wdata);
      mem[reg_addr] = reg_wdata;
    end
    if (txena) begin
      if (txbusy || prev_txena) tx_viol++;
      tx_q.push_back(txdw);
      if (cyc - last_tx < min_gap) min_gap = cyc - last_tx;
      last_tx = cyc;
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_txena = txena;
    txbusy = (busy_cnt != 0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle rxrdy pulse followed by a two-cycle gap; called at a negedge.
  task automatic send(input logic [7:0] b);
    rxdw  = b;
    rxrdy = 1'b1;
    @(negedge clk);
    rxrdy = 1'b0;
    idle(2);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) @(negedge clk);
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    tx_q.delete();
  endtask

  initial begin
    rst    = 1'b1;
    rxdw   = 8'h00;
    rxrdy  = 1'b0;
    txbusy = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    idle(3);

    // Reset state
    check("rst_txena", txena, 0);
    check("rst_txdw", txdw, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_sleds", sleds, 0);
    rst = 1'b0;
    idle(2);

    // Write burst 57,02,03,AA,BB,CC
    clear_logs();
    send(8'h57); send(8'h02); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    idle(2);
    check("wr_count", wa_q.size(), 3);
    check("wr_a0", wa_q[0], 8'h02); check("wr_d0", wd_q[0], 8'hAA);
    check("wr_a1", wa_q[1], 8'h03); check("wr_d1", wd_q[1], 8'hBB);
    check("wr_a2", wa_q[2], 8'h04); check("wr_d2", wd_q[2], 8'hCC);
    check("wr_busy", busy, 0);
    check("wr_err", err, 0);

    // Read burst 52,05,02 from preloaded bank
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    clear_logs();
    tx_viol = 0;
    min_gap = 1000;
    send(8'h52); send(8'h05); send(8'h02);
    wait_idle(200);
    idle(2);
    check("rd_busy", busy, 0);
    check("rd_count", tx_q.size(), 2);
    check("rd_b0", tx_q[0], 8'h15);
    check("rd_b1", tx_q[1], 8'h16);
    check("rd_handshake_viol", tx_viol, 0);
    check("rd_gap_ge3", (min_gap >= 3), 1);
    check("rd_txdw_held", txdw, 8'h16);
    check("rd_err", err, 0);

    // Wrap-around: 57,06,04 + 4 bytes -> 6,7,0,1
    clear_logs();
    send(8'h57); send(8'h06); send(8'h04);
    send(8'hD0); send(8'hD1); send(8'hD2); send(8'hD3);
    check("wrap_count", wa_q.size(), 4);
    check("wrap_a0", wa_q[0], 8'h06); check("wrap_d0", wd_q[0], 8'hD0);
    check("wrap_a1", wa_q[1], 8'h07); check("wrap_d1", wd_q[1], 8'hD1);
    check("wrap_a2", wa_q[2], 8'h00); check("wrap_d2", wd_q[2], 8'hD2);
    check("wrap_a3", wa_q[3], 8'h01); check("wrap_d3", wd_q[3], 8'hD3);

    // Zero length read
    clear_logs();
    send(8'h52); send(8'h00); send(8'h00);
    idle(4);
    check("zlen_err", err, 2'b10);
    check("zlen_busy", busy, 0);
    check("zlen_no_tx", tx_q.size(), 0);

    // Timeout: 57,01,03,AA then silence
    clear_logs();
    send(8'h57); send(8'h01); send(8'h03);
    send(8'hAA);
    idle(10);
    check("to_err_pending", err, 2'b00);
    check("to_busy_pending", busy, 1);
    idle(10);
    check("to_err", err, 2'b11);
    check("to_sleds", sleds, 4'd0);
    check("to_busy", busy, 0);
    check("to_count", wa_q.size(), 1);
    check("to_a0", wa_q[0], 8'h01);
    check("to_d0", wd_q[0], 8'hAA);

    // Timer boundary: len byte arrives exactly on the terminal-count cycle
    clear_logs();
    send(8'h57);
    rxdw = 8'h03; rxrdy = 1'b1; @(negedge clk); rxrdy = 1'b0;
    idle(TO);
    send(8'h02);
    send(8'hE0); send(8'hE1);
    check("tb_count", wa_q.size(), 2);
    check("tb_a0", wa_q[0], 8'h03); check("tb_d0", wd_q[0], 8'hE0);
    check("tb_a1", wa_q[1], 8'h04); check("tb_d1", wd_q[1], 8'hE1);
    check("tb_err", err, 2'b00);

    // Unknown command and recovery
    clear_logs();
    send(8'h41);
    check("unk_err", err, 2'b01);
    check("unk_busy", busy, 0);
    send(8'h57);
    check("unk_clear", err, 2'b00);
    send(8'h00); send(8'h01); send(8'h5A);
    check("unk_count", wa_q.size(), 1);
    check("unk_a0", wa_q[0], 8'h00);
    check("unk_d0", wd_q[0], 8'h5A);

    // Reset mid-write
    clear_logs();
    send(8'h57); send(8'h00); send(8'h04); send(8'h11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_txena", txena, 0);
    check("mrst_txdw", txdw, 0);
    check("mrst_reg_we", reg_we, 0);
    check("mrst_reg_addr", reg_addr, 0);
    check("mrst_reg_wdata", reg_wdata, 0);
    check("mrst_busy", busy, 0);
    check("mrst_err", err, 0);
    check("mrst_sleds", sleds, 0);
    send(8'h22);
    idle(3);
    check("mrst_err_unk", err, 2'b01);
    check("mrst_count", wa_q.size(), 1);
    check("mrst_a0", wa_q[0], 8'h00);
    check("mrst_d0", wd_q[0], 8'h11);
    check("mrst_busy_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
